// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: passes ALU results through, and runs loads/stores
// over a req/ack data bus with a small IDLE/BUSY/DONE FSM and a bus timeout.
module mem_stage #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_sdata_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stall_req,
  output logic        misalign,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        is_load, is_store, is_mem, sz_b, sz_h, sz_w, is_unsigned, misal_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [1:0]  a_lo;

  assign a_lo = mem_wdata_i[1:0];

  always_comb begin
    is_load     = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    is_store    = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
    is_mem      = is_load || is_store;
    sz_b        = (mem_op_i == 4'd1) || (mem_op_i == 4'd4) || (mem_op_i == 4'd6);
    sz_h        = (mem_op_i == 4'd2) || (mem_op_i == 4'd5) || (mem_op_i == 4'd7);
    sz_w        = (mem_op_i == 4'd3) || (mem_op_i == 4'd8);
    is_unsigned = (mem_op_i == 4'd4) || (mem_op_i == 4'd5);
    misal_c     = (sz_h && a_lo[0]) || (sz_w && (a_lo != 2'b00));
    be_c        = 4'b1111;
    wdata_c     = mem_sdata_i;
    if (sz_b) begin
      be_c    = 4'b0001 << a_lo;
      wdata_c = {4{mem_sdata_i[7:0]}};
    end else if (sz_h) begin
      be_c    = a_lo[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{mem_sdata_i[15:0]}};
    end
  end

  // Load formatting reads the buffered word; the address is still held upstream in DONE.
  always_comb begin
    lane_b = rdata_q[8*a_lo +: 8];
    lane_h = a_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_c = rdata_q;
    if (sz_b) load_c = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
    else if (sz_h) load_c = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem && !misal_c) begin
          addr_d  = {mem_wdata_i[31:2], 2'b00};
          we_d    = is_store;
          be_d    = be_c;
          wdata_d = wdata_c;
          req_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_ack) begin
          rdata_d = bus_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    wb_wd     = mem_wd_i;
    wb_wreg   = 1'b0;
    wb_wdata  = 32'd0;
    stall_req = 1'b0;
    misalign  = 1'b0;
    err       = 1'b0;
    if (rst) begin
      wb_wd = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!is_mem) begin
            wb_wreg  = mem_wreg_i;
            wb_wdata = mem_wdata_i;
          end else if (misal_c) begin
            misalign = 1'b1;
          end else begin
            stall_req = 1'b1;
          end
        end
        S_BUSY: stall_req = 1'b1;
        S_DONE: begin
          err = err_q;
          if (is_load && !err_q) begin
            wb_wreg  = mem_wreg_i;
            wb_wdata = load_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_be      = be_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalign, timeout and reset abort.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_sdata_i;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [4:0]  wb_wd;
  logic        wb_wreg, stall_req, misalign, err;
  logic [31:0] wb_wdata;
  logic [1:0]  dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  mem_stage #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_op_i(mem_op_i), .mem_sdata_i(mem_sdata_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stall_req(stall_req), .misalign(misalign), .err(err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] sdata);
    mem_op_i    = op;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = wdata;
    mem_sdata_i = sdata;
  endtask

  // Full load: IDLE request, optional wait cycles, ack, then DONE writeback check.
  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input int waits, input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    set_instr(op, 5'd9, 1'b1, addr, 32'd0);
    @(negedge clk);
    check_eq({tag, "_idle_stall"}, 32'(stall_req), 32'd1);
    tick();
    for (int i = 0; i < waits; i++) tick();
    @(negedge clk);
    check_eq({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
    check_eq({tag, "_be"}, 32'(bus_be), 32'(exp_be));
    check_eq({tag, "_req"}, 32'(bus_req), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'hDEAD_0000;
    @(negedge clk);
    check_eq({tag, "_data"}, wb_wdata, exp_data);
    check_eq({tag, "_wreg"}, 32'(wb_wreg), 32'd1);
    check_eq({tag, "_done_stall"}, 32'(stall_req), 32'd0);
    tick();
    set_instr(4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    int stall_cycles;
    stall_cycles = 0;
    set_instr(op, 5'd3, 1'b1, addr, sdata);
    @(negedge clk);
    if (stall_req) stall_cycles++;
    tick();
    @(negedge clk);
    if (stall_req) stall_cycles++;
    check_eq({tag, "_we"}, 32'(bus_we), 32'd1);
    check_eq({tag, "_be"}, 32'(bus_be), 32'(exp_be));
    check_eq({tag, "_wdata"}, bus_wdata, exp_wdata);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    if (stall_req) stall_cycles++;
    check_eq({tag, "_wreg"}, 32'(wb_wreg), 32'd0);
    check_eq({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd2);
    tick();
    set_instr(4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    set_instr(4'd0, 5'd7, 1'b1, 32'h55, 32'd0);
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_wb_wd", 32'(wb_wd), 32'd0);
    check_eq("rst_wb_wreg", 32'(wb_wreg), 32'd0);
    check_eq("rst_wb_wdata", wb_wdata, 32'd0);
    check_eq("rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("rst_bus_be", 32'(bus_be), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;

    // Pass-through, including an undefined op code treated as NOP
    set_instr(4'd0, 5'd5, 1'b1, 32'h1234, 32'd0);
    @(negedge clk);
    check_eq("nop_wdata", wb_wdata, 32'h1234);
    check_eq("nop_wd", 32'(wb_wd), 32'd5);
    check_eq("nop_wreg", 32'(wb_wreg), 32'd1);
    check_eq("nop_stall", 32'(stall_req), 32'd0);
    tick();
    set_instr(4'd12, 5'd17, 1'b1, 32'hCAFE_F00D, 32'd0);
    @(negedge clk);
    check_eq("op12_wdata", wb_wdata, 32'hCAFE_F00D);
    check_eq("op12_stall", 32'(stall_req), 32'd0);
    tick();

    run_load("lb",  4'd1, 32'h103, 0, 32'h80FF_FF7F, 4'b1000, 32'hFFFF_FF80);
    run_load("lbu", 4'd4, 32'h103, 0, 32'h80FF_FF7F, 4'b1000, 32'h0000_0080);
    run_load("lb0", 4'd1, 32'h100, 0, 32'h80FF_FF7F, 4'b0001, 32'h0000_007F);
    run_load("lh",  4'd2, 32'h102, 0, 32'h80FF_FF7F, 4'b1100, 32'hFFFF_80FF);
    run_load("lhu", 4'd5, 32'h102, 0, 32'h80FF_FF7F, 4'b1100, 32'h0000_80FF);
    run_load("lw",  4'd3, 32'h104, 2, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    run_store("sh", 4'd7, 32'h202, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
    run_store("sb", 4'd6, 32'h201, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    run_store("sw", 4'd8, 32'h200, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    // Misaligned word load
    set_instr(4'd3, 5'd4, 1'b1, 32'h201, 32'd0);
    @(negedge clk);
    check_eq("mis_flag", 32'(misalign), 32'd1);
    check_eq("mis_wreg", 32'(wb_wreg), 32'd0);
    check_eq("mis_stall", 32'(stall_req), 32'd0);
    tick();
    set_instr(4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq("mis_flag_clear", 32'(misalign), 32'd0);
    check_eq("mis_no_req", 32'(bus_req), 32'd0);
    tick();

    // Timeout: no ack ever arrives
    set_instr(4'd3, 5'd6, 1'b1, 32'h300, 32'd0);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_req) break;
      n++;
      tick();
    end
    check_eq("to_req_cycles", 32'(n), 32'd8);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_wreg", 32'(wb_wreg), 32'd0);
    check_eq("to_state", 32'(dbg_state), 32'(ST_DONE));
    tick();
    set_instr(4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq("to_err_clear", 32'(err), 32'd0);
    check_eq("to_idle", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    // Reset in the second BUSY cycle aborts the access; a late ack is ignored
    set_instr(4'd3, 5'd8, 1'b1, 32'h400, 32'd0);
    tick();
    tick();
    @(negedge clk);
    check_eq("ra_busy", 32'(dbg_state), 32'(ST_BUSY));
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("ra_req", 32'(bus_req), 32'd0);
    check_eq("ra_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    set_instr(4'd0, 5'd2, 1'b1, 32'h77, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("ra_late_ack_wdata", wb_wdata, 32'h77);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    check_eq("ra_late_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("ra_late_ack_req", 32'(bus_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
